// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round constants, row-major byte
// addressing and the key-schedule sequencer states.
package aes_pkg;

  typedef enum logic [2:0] {
    KS_IDLE,
    KS_ISS0,
    KS_ISS1,
    KS_ISS2,
    KS_ISS3,
    KS_FIN
  } ks_state_t;

  // Out-of-range rounds deliberately map to 00 rather than flagging an error.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic int unsigned byte_msb(input int unsigned row, input int unsigned col);
    return 127 - 32 * row - 8 * col;
  endfunction

endpackage

// File: rtl/keyexp_inv.sv
// Inverse AES-128 key-schedule step: K(r) -> K(r-1), using an external shared
// forward S-box with one-cycle read latency.
//
// state   | meaning
// IDLE    | waiting for start_in; latches key_in/round_in on accept
// ISS0    | look up w3 row 1
// ISS1    | look up w3 row 2, capture t[0]
// ISS2    | look up w3 row 3, capture t[1]
// ISS3    | look up w3 row 0, capture t[2]
// FIN     | t[3] live from sbox_out, form K(r-1), pulse ready_out
module keyexp_inv
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_in,
  input  logic [7:0]   sbox_out,
  output logic [127:0] key_out,
  output logic         ready_out,
  output logic         busy_out,
  output logic [7:0]   sbox_in,
  output logic         sbox_en_de_in,
  output logic         ce,
  output logic         re
);

  ks_state_t    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [23:0]  t_q, t_d;
  logic [127:0] kout_q, kout_d;

  logic [31:0]  w_in [4];
  logic [31:0]  w_new [4];
  logic [127:0] key_new;

  // Columns w4..w7 of K(r) land in w_in[0..3]; w_new[0..3] is w0..w3 of K(r-1).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_in[c][31-8*r -: 8] = key_q[byte_msb(r, c) -: 8];
      end
    end
    w_new[3] = w_in[3] ^ w_in[2];
    w_new[2] = w_in[2] ^ w_in[1];
    w_new[1] = w_in[1] ^ w_in[0];
    w_new[0] = w_in[0] ^ {t_q, sbox_out} ^ {rcon(round_q), 24'h000000};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        key_new[byte_msb(r, c) -: 8] = w_new[c][31-8*r -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KS_IDLE;
      key_q   <= '0;
      round_q <= '0;
      t_q     <= '0;
      kout_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      t_q     <= t_d;
      kout_q  <= kout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    t_d       = t_q;
    kout_d    = kout_q;
    sbox_in   = 8'h00;
    ce        = 1'b0;
    ready_out = 1'b0;
    busy_out  = (state_q != KS_IDLE);
    case (state_q)
      KS_IDLE: begin
        if (start_in) begin
          key_d   = key_in;
          round_d = round_in;
          state_d = KS_ISS0;
        end
      end
      KS_ISS0: begin
        sbox_in = w_new[3][23:16];
        ce      = 1'b1;
        state_d = KS_ISS1;
      end
      KS_ISS1: begin
        sbox_in      = w_new[3][15:8];
        ce           = 1'b1;
        t_d[23:16]   = sbox_out;
        state_d      = KS_ISS2;
      end
      KS_ISS2: begin
        sbox_in      = w_new[3][7:0];
        ce           = 1'b1;
        t_d[15:8]    = sbox_out;
        state_d      = KS_ISS3;
      end
      KS_ISS3: begin
        sbox_in      = w_new[3][31:24];
        ce           = 1'b1;
        t_d[7:0]     = sbox_out;
        state_d      = KS_FIN;
      end
      KS_FIN: begin
        ready_out = 1'b1;
        kout_d    = key_new;
        state_d   = KS_IDLE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // FIN bypasses the register so the result is visible in the ready cycle.
  assign key_out       = (state_q == KS_FIN) ? key_new : kout_q;
  assign re            = ce;
  assign sbox_en_de_in = 1'b1;

endmodule

// File: tb/tb_keyexp_inv.sv
// Directed bench for keyexp_inv with a behavioural one-cycle forward S-box.
module tb_keyexp_inv;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [127:0] key_in;
  logic [3:0]   round_in;
  logic [7:0]   sbox_out = 8'h00;
  logic [127:0] key_out;
  logic         ready_out;
  logic         busy_out;
  logic [7:0]   sbox_in;
  logic         sbox_en_de_in;
  logic         ce;
  logic         re;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RC = 80'h01020408102040801b36;

  keyexp_inv dut (
    .clk(clk), .rst(rst), .start_in(start_in), .key_in(key_in), .round_in(round_in),
    .sbox_out(sbox_out), .key_out(key_out), .ready_out(ready_out), .busy_out(busy_out),
    .sbox_in(sbox_in), .sbox_en_de_in(sbox_en_de_in), .ce(ce), .re(re)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    return SBOX[2047 - 8 * int'(a) -: 8];
  endfunction

  always @(posedge clk) if (ce && re) sbox_out <= sbox_f(sbox_in);

  function automatic logic [31:0] col(input logic [127:0] k, input int c);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = k[127-32*i-8*c -: 8];
    return w;
  endfunction

  function automatic logic [127:0] pack(input logic [31:0] w0, w1, w2, w3);
    logic [127:0] k;
    logic [31:0]  w [4];
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) k[127-32*i-8*c -: 8] = w[c][31-8*i -: 8];
    return k;
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] a, b, c, d, n0, n1, n2, n3, rot, sub;
    logic [7:0]  rc;
    a = col(k, 0); b = col(k, 1); c = col(k, 2); d = col(k, 3);
    n3 = d ^ c; n2 = c ^ b; n1 = b ^ a;
    rot = {n3[23:0], n3[31:24]};
    for (int i = 0; i < 4; i++) sub[8*i +: 8] = sbox_f(rot[8*i +: 8]);
    rc = (r >= 4'd1 && r <= 4'd10) ? RC[79 - 8 * (int'(r) - 1) -: 8] : 8'h00;
    n0 = a ^ sub ^ {rc, 24'h000000};
    return pack(n0, n1, n2, n3);
  endfunction

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT idle; leaves at the falling edge of T+6 (still idle).
  task automatic do_req(input logic [127:0] k, input logic [3:0] r,
                        input logic [127:0] exp, input string tag);
    logic [31:0] w3;
    logic [7:0]  ea [4];
    w3 = col(k, 3) ^ col(k, 2);
    ea = '{w3[23:16], w3[15:8], w3[7:0], w3[31:24]};
    start_in = 1'b1; key_in = k; round_in = r;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq({tag, "_addr"}, 128'(sbox_in), 128'(ea[i]));
      chk_eq({tag, "_ce_re"}, 128'({ce, re}), 128'(2'b11));
      chk_eq({tag, "_busy_iss"}, 128'(busy_out), 128'(1'b1));
      chk_eq({tag, "_ready_early"}, 128'(ready_out), 128'(1'b0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_eq({tag, "_ready"}, 128'(ready_out), 128'(1'b1));
    chk_eq({tag, "_busy_fin"}, 128'(busy_out), 128'(1'b1));
    chk_eq({tag, "_idle_addr"}, 128'({sbox_in, ce, re}), 128'(0));
    chk_eq({tag, "_key"}, key_out, exp);
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq({tag, "_ready_off"}, 128'(ready_out), 128'(1'b0));
    chk_eq({tag, "_busy_off"}, 128'(busy_out), 128'(1'b0));
    chk_eq({tag, "_key_hold"}, key_out, exp);
  endtask

  logic [127:0] K10, K9, K9_NORC, K1, K0, cur, nxt;

  initial begin
    K10     = pack(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
    K9      = pack(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
    K9_NORC = pack(32'h9a7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
    K1      = pack(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
    K0      = pack(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);

    // Reset with start held high and random inputs: reset must win.
    rst = 1'b1; start_in = 1'b1;
    repeat (3) begin
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      round_in = 4'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_eq("rst_key_out", key_out, 128'h0);
    chk_eq("rst_ready", 128'(ready_out), 128'(0));
    chk_eq("rst_busy", 128'(busy_out), 128'(0));
    chk_eq("rst_sbox_in", 128'(sbox_in), 128'(0));
    chk_eq("rst_ce_re", 128'({ce, re}), 128'(0));
    chk_eq("rst_en_de", 128'(sbox_en_de_in), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0; start_in = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_busy", 128'(busy_out), 128'(0));
    @(posedge clk); #1;

    do_req(K10, 4'd10, K9, "fips_r10");
    do_req(K1, 4'd1, K0, "fips_r1");
    do_req(K10, 4'd0, K9_NORC, "round0");
    do_req(K10, 4'd11, K9_NORC, "round11");
    do_req(K10, 4'd15, K9_NORC, "round15");

    cur = K10;
    for (int r = 10; r >= 1; r--) begin
      nxt = inv_step(cur, 4'(r));
      do_req(cur, 4'(r), nxt, $sformatf("walk%0d", r));
      cur = nxt;
    end
    chk_eq("walk_final", key_out, K0);

    // start_in held high: accepts at T, T+6, T+12; key_in disturbed while busy.
    @(posedge clk); #1;
    start_in = 1'b1; key_in = K10; round_in = 4'd10;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk_eq($sformatf("hold_ready%0d", i), 128'(ready_out),
             128'((i == 5 || i == 11 || i == 17) ? 1 : 0));
      chk_eq($sformatf("hold_busy%0d", i), 128'(busy_out), 128'((i % 6 != 0) ? 1 : 0));
      if (i == 5 || i == 11 || i == 17) chk_eq($sformatf("hold_key%0d", i), key_out, K9);
      @(posedge clk); #1;
      if (((i + 1) % 6) >= 1 && ((i + 1) % 6) <= 4) begin
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        round_in = 4'($urandom);
      end else begin
        key_in = K10; round_in = 4'd10;
      end
      if (i + 1 == 13) start_in = 1'b0;
    end
    start_in = 1'b0;

    // Abort with reset in T+3.
    start_in = 1'b1; key_in = K10; round_in = 4'd10;
    @(posedge clk); #1; start_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_ready_t3", 128'(ready_out), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("abort_ready", 128'(ready_out), 128'(0));
      chk_eq("abort_busy", 128'(busy_out), 128'(0));
      chk_eq("abort_key", key_out, 128'h0);
      @(posedge clk); #1;
    end
    do_req(K10, 4'd10, K9, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
